// File: rtl/core_ex_mdu_if.sv
// Request/response bundle between the issue logic and the multiply/divide unit.
// The issue side is the master; the MDU is the slave.
interface core_ex_mdu_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [XLEN-1:0]  req_rs1;
    logic [XLEN-1:0]  req_rs2;
    logic [TAG_W-1:0] req_tag;
    logic             resp_valid;
    logic             resp_ready;
    logic [XLEN-1:0]  resp_data;
    logic [TAG_W-1:0] resp_tag;

    modport master (
        output req_valid, req_op, req_rs1, req_rs2, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_tag
    );

    modport slave (
        input  req_valid, req_op, req_rs1, req_rs2, req_tag, resp_ready,
        output req_ready, resp_valid, resp_data, resp_tag
    );
endinterface

// File: rtl/core_ex_mdu.sv
// Iterative radix-2 multiply/divide unit for RV32M/RV64M.
// Operands are converted to magnitudes, iterated one bit per cycle,
// then the sign is restored in a single fixup cycle.
module core_ex_mdu #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    output logic          busy,
    core_ex_mdu_if.slave  mdu
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             sign1_q, sign1_d;
    logic             neg_q, neg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN:0]    acc_q, acc_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic [XLEN-1:0]  b_q, b_d;
    logic             resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]  resp_data_q, resp_data_d;
    logic [TAG_W-1:0] resp_tag_q, resp_tag_d;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    // Request decode: operand signedness and divide fast-path detection
    logic            accept, rs1_signed, rs2_signed, s1, s2;
    logic            req_is_div, div_zero, div_ovf;
    logic [XLEN-1:0] mag1, mag2, fast_result;

    assign mdu.req_ready = (state_q == IDLE) && !flush;
    assign accept        = mdu.req_valid && mdu.req_ready;
    assign rs1_signed    = (mdu.req_op == 3'd1) || (mdu.req_op == 3'd2) ||
                           (mdu.req_op[2] && !mdu.req_op[0]);
    assign rs2_signed    = (mdu.req_op == 3'd1) || (mdu.req_op[2] && !mdu.req_op[0]);
    assign s1            = rs1_signed && mdu.req_rs1[XLEN-1];
    assign s2            = rs2_signed && mdu.req_rs2[XLEN-1];
    assign mag1          = cond_neg(mdu.req_rs1, s1);
    assign mag2          = cond_neg(mdu.req_rs2, s2);
    assign req_is_div    = mdu.req_op[2];
    assign div_zero      = (mdu.req_rs2 == '0);
    assign div_ovf       = mdu.req_op[2] && !mdu.req_op[0] &&
                           (mdu.req_rs1 == MIN) && (mdu.req_rs2 == '1);
    // Divide by zero: quotient all ones, remainder is the dividend.
    // Signed overflow: quotient is the dividend, remainder zero.
    assign fast_result   = div_zero ? (mdu.req_op[1] ? mdu.req_rs1 : '1)
                                    : (mdu.req_op[1] ? '0 : mdu.req_rs1);

    // One iteration step: shift-add for multiply, restoring subtract for divide
    logic [XLEN:0] mul_sum, rem_sh, div_rem;
    logic          div_ge;

    assign mul_sum = acc_q + (lo_q[0] ? {1'b0, b_q} : '0);
    assign rem_sh  = {acc_q[XLEN-1:0], lo_q[XLEN-1]};
    assign div_ge  = (rem_sh >= {1'b0, b_q});
    assign div_rem = div_ge ? (rem_sh - {1'b0, b_q}) : rem_sh;

    // Sign restoration and result selection for the fixup cycle
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

    assign prod       = {acc_q[XLEN-1:0], lo_q};
    assign prod_fix   = neg_q ? -prod : prod;
    assign quo_fix    = cond_neg(lo_q, neg_q);
    assign rem_fix    = cond_neg(acc_q[XLEN-1:0], sign1_q);
    assign fix_result = op_q[2] ? (op_q[1] ? rem_fix : quo_fix)
                                : ((op_q == 3'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);

    // Next-state logic for the FSM, iteration registers and response registers
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        tag_d        = tag_q;
        sign1_d      = sign1_q;
        neg_d        = neg_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        lo_d         = lo_q;
        b_d          = b_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_tag_d   = resp_tag_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = mdu.req_op;
                    tag_d   = mdu.req_tag;
                    sign1_d = s1;
                    neg_d   = s1 ^ s2;
                    if (req_is_div && (div_zero || div_ovf)) begin
                        state_d      = DONE;
                        resp_valid_d = 1'b1;
                        resp_data_d  = fast_result;
                        resp_tag_d   = mdu.req_tag;
                    end else begin
                        state_d = CALC;
                        cnt_d   = CNT_W'(XLEN - 1);
                        acc_d   = '0;
                        b_d     = req_is_div ? mag2 : mag1;
                        lo_d    = req_is_div ? mag1 : mag2;
                    end
                end
            end
            CALC: begin
                if (op_q[2]) begin
                    acc_d = div_rem;
                    lo_d  = {lo_q[XLEN-2:0], div_ge};
                end else begin
                    acc_d = {1'b0, mul_sum[XLEN:1]};
                    lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
                end
                if (cnt_q == '0) state_d = FIXUP;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            FIXUP: begin
                state_d      = DONE;
                resp_valid_d = 1'b1;
                resp_data_d  = fix_result;
                resp_tag_d   = tag_q;
            end
            DONE: begin
                if (mdu.resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Flush wins over everything: drop the op and any held result
        if (flush) begin
            state_d      = IDLE;
            resp_valid_d = 1'b0;
        end
    end

    // Control state and visible response registers, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_tag_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_tag_q   <= resp_tag_d;
        end
    end

    // Datapath registers; always loaded before use so they need no reset
    always_ff @(posedge clk) begin
        op_q    <= op_d;
        tag_q   <= tag_d;
        sign1_q <= sign1_d;
        neg_q   <= neg_d;
        acc_q   <= acc_d;
        lo_q    <= lo_d;
        b_q     <= b_d;
    end

    assign busy           = (state_q != IDLE);
    assign mdu.resp_valid = resp_valid_q;
    assign mdu.resp_data  = resp_data_q;
    assign mdu.resp_tag   = resp_tag_q;
endmodule
